memorystage: RTL and testbench

Memory-access stage of the RV32I pipeline. It sits directly after the execute stage and consumes that stage's address, data, destination-register and function outputs. It performs the load or store on a request/acknowledge data-memory port, aligns and extends load data, and presents writeback data. It back-pressures the execute stage with `stall_out` while a memory access is outstanding.

---
 rtl/memorystage.sv | 278 +++++++++++++++++++++++++++
 tb/tb_memorystage.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memorystage.sv
// ============================================================================
// memorystage - RV32I memory-access pipeline stage
//
// Sits after execute. Non-memory ops pass straight through to writeback with
// one cycle of latency. Loads/stores run a request/acknowledge transaction on
// the data-memory port while holding execute via stall_out. Load data is lane
// aligned and sign/zero extended. Misaligned accesses and timeouts produce a
// single-cycle status pulse and no writeback.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   addr_in         effective address from execute
//   data_in         ALU result / store data from execute
//   rd_in, func_in  destination register and operation code from execute
//   stall_out       execute must hold its outputs (state is BUSY)
//   mem_req/we      memory request valid / write
//   mem_addr        word-aligned address
//   mem_wdata/wstrb lane-replicated store data / byte enables
//   mem_rdata/ack   read data and one-cycle completion pulse
//   wb_data, rd_out, wb_en, func_out  writeback interface
//   misalign        pulse: misaligned load/store dropped
//   bus_err         pulse: access aborted after TIMEOUT cycles without ack
// ============================================================================
module memorystage #(
    parameter int unsigned width   = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] addr_in,
    input  logic [width-1:0] data_in,
    input  logic [4:0]       rd_in,
    input  logic [5:0]       func_in,
    output logic             stall_out,
    output logic             mem_req,
    output logic             mem_we,
    output logic [width-1:0] mem_addr,
    output logic [width-1:0] mem_wdata,
    output logic [3:0]       mem_wstrb,
    input  logic [width-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic [width-1:0] wb_data,
    output logic [4:0]       rd_out,
    output logic             wb_en,
    output logic [5:0]       func_out,
    output logic             misalign,
    output logic             bus_err
);

    // Function codes (rv32i_defs encoding)
    localparam logic [5:0] F_NOP   = 6'h00;
    localparam logic [5:0] F_ALU_LO = 6'h01;  // first ALU code (ADD)
    localparam logic [5:0] F_JALR  = 6'h17;   // ALU..LUI,AUIPC,JAL,JALR contiguous
    localparam logic [5:0] F_LB    = 6'h20;
    localparam logic [5:0] F_LH    = 6'h21;
    localparam logic [5:0] F_LW    = 6'h22;
    localparam logic [5:0] F_LBU   = 6'h23;
    localparam logic [5:0] F_LHU   = 6'h24;
    localparam logic [5:0] F_SB    = 6'h28;
    localparam logic [5:0] F_SH    = 6'h29;
    localparam logic [5:0] F_SW    = 6'h2A;

    localparam int unsigned CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {S_IDLE, S_BUSY} state_t;

    function automatic logic f_is_load(input logic [5:0] f);
        return (f == F_LB) || (f == F_LH) || (f == F_LW) ||
               (f == F_LBU) || (f == F_LHU);
    endfunction

    function automatic logic f_is_store(input logic [5:0] f);
        return (f == F_SB) || (f == F_SH) || (f == F_SW);
    endfunction

    state_t           r_state, w_state_n;
    logic [width-1:0] r_wb_data, w_wb_data_n;
    logic [width-1:0] r_mem_addr, w_mem_addr_n;
    logic [width-1:0] r_mem_wdata, w_mem_wdata_n;
    logic [3:0]       r_mem_wstrb, w_mem_wstrb_n;
    logic             r_mem_we, w_mem_we_n;
    logic [4:0]       r_rd_out, w_rd_out_n;
    logic [5:0]       r_func_out, w_func_out_n;
    logic [5:0]       r_acc_func, w_acc_func_n;
    logic [1:0]       r_lane, w_lane_n;
    logic             r_wb_en, w_wb_en_n;
    logic             r_misalign, w_misalign_n;
    logic             r_bus_err, w_bus_err_n;
    logic [CW-1:0]    r_cnt, w_cnt_n, w_cnt_inc;

    logic             w_in_load, w_in_store, w_in_wb_op, w_in_aligned;
    logic             w_timeout;
    logic [width-1:0] w_st_wdata;
    logic [3:0]       w_st_strb;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [width-1:0] w_load_val;

    // ------------------------------------------------------------------
    // Input decode
    // ------------------------------------------------------------------
    assign w_in_load  = f_is_load(func_in);
    assign w_in_store = f_is_store(func_in);
    assign w_in_wb_op = (func_in >= F_ALU_LO) && (func_in <= F_JALR);

    always_comb begin
        w_in_aligned = 1'b1;
        if (func_in == F_LW || func_in == F_SW)
            w_in_aligned = (addr_in[1:0] == 2'b00);
        else if (func_in == F_LH || func_in == F_LHU || func_in == F_SH)
            w_in_aligned = ~addr_in[0];
    end

    always_comb begin
        w_st_wdata = '0;
        w_st_strb  = '0;
        case (func_in)
            F_SB: begin
                w_st_wdata = {4{data_in[7:0]}};
                w_st_strb  = 4'b0001 << addr_in[1:0];
            end
            F_SH: begin
                w_st_wdata = {2{data_in[15:0]}};
                w_st_strb  = addr_in[1] ? 4'b1100 : 4'b0011;
            end
            F_SW: begin
                w_st_wdata = data_in;
                w_st_strb  = 4'b1111;
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Load data alignment / extension (uses lane captured at request)
    // ------------------------------------------------------------------
    always_comb begin
        case (r_lane)
            2'd0:    w_byte = mem_rdata[7:0];
            2'd1:    w_byte = mem_rdata[15:8];
            2'd2:    w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_acc_func)
            F_LB:    w_load_val = {{(width-8){w_byte[7]}}, w_byte};
            F_LBU:   w_load_val = {{(width-8){1'b0}}, w_byte};
            F_LH:    w_load_val = {{(width-16){w_half[15]}}, w_half};
            F_LHU:   w_load_val = {{(width-16){1'b0}}, w_half};
            default: w_load_val = mem_rdata;
        endcase
    end

    // Abort when this BUSY cycle would bring the count to TIMEOUT; an ack in
    // the same cycle takes priority in the next-state logic below.
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_timeout = (TIMEOUT != 0) && (w_cnt_inc == CW'(TIMEOUT));

    // ------------------------------------------------------------------
    // Next-state / next-output logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_n     = r_state;
        w_wb_data_n   = r_wb_data;
        w_mem_addr_n  = r_mem_addr;
        w_mem_wdata_n = r_mem_wdata;
        w_mem_wstrb_n = r_mem_wstrb;
        w_mem_we_n    = r_mem_we;
        w_rd_out_n    = r_rd_out;
        w_func_out_n  = r_func_out;
        w_acc_func_n  = r_acc_func;
        w_lane_n      = r_lane;
        w_wb_en_n     = r_wb_en;
        w_misalign_n  = 1'b0;
        w_bus_err_n   = 1'b0;
        w_cnt_n       = r_cnt;

        case (r_state)
            S_IDLE: begin
                if (w_in_load || w_in_store) begin
                    w_func_out_n = F_NOP;
                    w_wb_en_n    = 1'b0;
                    if (w_in_aligned) begin
                        w_state_n     = S_BUSY;
                        w_cnt_n       = '0;
                        w_mem_addr_n  = {addr_in[width-1:2], 2'b00};
                        w_mem_we_n    = w_in_store;
                        w_mem_wdata_n = w_st_wdata;
                        w_mem_wstrb_n = w_st_strb;
                        w_acc_func_n  = func_in;
                        w_lane_n      = addr_in[1:0];
                        // rd_out carries the access's destination through BUSY
                        w_rd_out_n    = rd_in;
                    end else begin
                        w_misalign_n = 1'b1;
                    end
                end else begin
                    w_wb_data_n  = data_in;
                    w_rd_out_n   = rd_in;
                    w_func_out_n = func_in;
                    w_wb_en_n    = w_in_wb_op && (rd_in != 5'd0);
                end
            end
            S_BUSY: begin
                if (mem_ack) begin
                    w_state_n    = S_IDLE;
                    w_func_out_n = r_acc_func;
                    if (f_is_load(r_acc_func)) begin
                        w_wb_data_n = w_load_val;
                        w_wb_en_n   = (r_rd_out != 5'd0);
                    end else begin
                        w_wb_en_n   = 1'b0;
                    end
                end else if (w_timeout) begin
                    w_state_n    = S_IDLE;
                    w_bus_err_n  = 1'b1;
                    w_func_out_n = F_NOP;
                    w_wb_en_n    = 1'b0;
                end else begin
                    w_cnt_n = w_cnt_inc;
                end
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_wb_data   <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_wstrb <= '0;
            r_mem_we    <= 1'b0;
            r_rd_out    <= '0;
            r_func_out  <= F_NOP;
            r_acc_func  <= F_NOP;
            r_lane      <= '0;
            r_wb_en     <= 1'b0;
            r_misalign  <= 1'b0;
            r_bus_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state     <= w_state_n;
            r_wb_data   <= w_wb_data_n;
            r_mem_addr  <= w_mem_addr_n;
            r_mem_wdata <= w_mem_wdata_n;
            r_mem_wstrb <= w_mem_wstrb_n;
            r_mem_we    <= w_mem_we_n;
            r_rd_out    <= w_rd_out_n;
            r_func_out  <= w_func_out_n;
            r_acc_func  <= w_acc_func_n;
            r_lane      <= w_lane_n;
            r_wb_en     <= w_wb_en_n;
            r_misalign  <= w_misalign_n;
            r_bus_err   <= w_bus_err_n;
            r_cnt       <= w_cnt_n;
        end
    end

    // Request and stall follow the state only, never mem_ack directly
    assign mem_req   = (r_state == S_BUSY);
    assign stall_out = (r_state == S_BUSY);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_wstrb = r_mem_wstrb;
    assign wb_data   = r_wb_data;
    assign rd_out    = r_rd_out;
    assign wb_en     = r_wb_en;
    assign func_out  = r_func_out;
    assign misalign  = r_misalign;
    assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_memorystage.sv
// ============================================================================
// tb_memorystage - directed self-checking bench for memorystage
// (TIMEOUT overridden to 4). Inputs change and outputs are sampled on the
// falling clock edge.
// ============================================================================
module tb_memorystage;

    localparam logic [5:0] F_NOP  = 6'h00;
    localparam logic [5:0] F_ADDI = 6'h0B;
    localparam logic [5:0] F_LUI  = 6'h14;
    localparam logic [5:0] F_BEQ  = 6'h18;
    localparam logic [5:0] F_LB   = 6'h20;
    localparam logic [5:0] F_LH   = 6'h21;
    localparam logic [5:0] F_LW   = 6'h22;
    localparam logic [5:0] F_LBU  = 6'h23;
    localparam logic [5:0] F_LHU  = 6'h24;
    localparam logic [5:0] F_SB   = 6'h28;
    localparam logic [5:0] F_SH   = 6'h29;
    localparam logic [5:0] F_SW   = 6'h2A;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr_in, data_in, mem_rdata;
    logic [4:0]  rd_in;
    logic [5:0]  func_in;
    logic        mem_ack;
    logic        stall_out, mem_req, mem_we, wb_en, misalign, bus_err;
    logic [31:0] mem_addr, mem_wdata, wb_data;
    logic [3:0]  mem_wstrb;
    logic [4:0]  rd_out;
    logic [5:0]  func_out;

    int n_cmp = 0;
    int n_err = 0;

    memorystage #(.width(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .addr_in(addr_in), .data_in(data_in), .rd_in(rd_in), .func_in(func_in),
        .stall_out(stall_out),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .wb_data(wb_data), .rd_out(rd_out), .wb_en(wb_en), .func_out(func_out),
        .misalign(misalign), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] d,
                         input logic [4:0] r);
        func_in = f; addr_in = a; data_in = d; rd_in = r;
    endtask

    // Issue a memory op (call at a falling edge); ack is presented in BUSY
    // cycle ack_cyc. Returns at the falling edge of the writeback cycle.
    task automatic run_mem(input string tag, input logic [5:0] f, input logic [31:0] a,
                           input logic [31:0] d, input logic [4:0] r,
                           input int ack_cyc, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                           input logic [31:0] exp_wdata, input logic exp_we,
                           output int stalls);
        stalls = 0;
        drive(f, a, d, r);
        for (int k = 1; k <= ack_cyc; k++) begin
            @(negedge clk);
            if (stall_out) stalls++;
            check({tag, ".req"},  {31'd0, mem_req}, 32'd1);
            check({tag, ".addr"}, mem_addr, exp_addr);
            if (k == 1) begin
                check({tag, ".strb"},  {28'd0, mem_wstrb}, {28'd0, exp_strb});
                check({tag, ".wdata"}, mem_wdata, exp_wdata);
                check({tag, ".we"},    {31'd0, mem_we}, {31'd0, exp_we});
                check({tag, ".busyfn"}, {26'd0, func_out}, {26'd0, F_NOP});
                check({tag, ".busywb"}, {31'd0, wb_en}, 32'd0);
            end
            if (k == ack_cyc) begin
                mem_ack = 1'b1;
                mem_rdata = rdata;
                drive(F_NOP, 32'd0, 32'd0, 5'd0);
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        check({tag, ".stall_after"}, {31'd0, stall_out}, 32'd0);
        check({tag, ".req_after"},   {31'd0, mem_req}, 32'd0);
        check({tag, ".berr"},        {31'd0, bus_err}, 32'd0);
    endtask

    int st;
    int reqs;

    initial begin
        rst = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
        drive(F_NOP, 32'd0, 32'd0, 5'd0);
        #1;
        check("rst.req",   {31'd0, mem_req}, 32'd0);
        check("rst.stall", {31'd0, stall_out}, 32'd0);
        check("rst.wben",  {31'd0, wb_en}, 32'd0);
        check("rst.func",  {26'd0, func_out}, {26'd0, F_NOP});
        check("rst.wbd",   wb_data, 32'd0);
        check("rst.strb",  {28'd0, mem_wstrb}, 32'd0);
        check("rst.rd",    {27'd0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Non-memory ops, back to back
        drive(F_ADDI, 32'd0, 32'h0000_1234, 5'd5);
        @(negedge clk);
        check("addi.wbd",   wb_data, 32'h0000_1234);
        check("addi.rd",    {27'd0, rd_out}, 32'd5);
        check("addi.wben",  {31'd0, wb_en}, 32'd1);
        check("addi.stall", {31'd0, stall_out}, 32'd0);
        check("addi.func",  {26'd0, func_out}, {26'd0, F_ADDI});
        drive(F_ADDI, 32'd0, 32'h0000_1234, 5'd0);
        @(negedge clk);
        check("addi_r0.wben", {31'd0, wb_en}, 32'd0);
        drive(F_LUI, 32'd0, 32'hABCD_E000, 5'd3);
        @(negedge clk);
        check("lui.wbd",  wb_data, 32'hABCD_E000);
        check("lui.wben", {31'd0, wb_en}, 32'd1);
        drive(F_BEQ, 32'd0, 32'd1, 5'd7);
        @(negedge clk);
        check("beq.wben", {31'd0, wb_en}, 32'd0);
        check("beq.func", {26'd0, func_out}, {26'd0, F_BEQ});

        // ack while idle is ignored
        drive(F_NOP, 32'd0, 32'd0, 5'd0);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        check("idleack.stall", {31'd0, stall_out}, 32'd0);
        check("idleack.req",   {31'd0, mem_req}, 32'd0);

        // Stores
        run_mem("sb", F_SB, 32'h103, 32'h0000_00AB, 5'd0, 3, 32'd0,
                32'h100, 4'b1000, 32'hABAB_ABAB, 1'b1, st);
        check("sb.stallcyc", st, 32'd3);
        check("sb.wben", {31'd0, wb_en}, 32'd0);
        check("sb.func", {26'd0, func_out}, {26'd0, F_SB});
        run_mem("sh", F_SH, 32'h102, 32'h1234_ABCD, 5'd1, 1, 32'd0,
                32'h100, 4'b1100, 32'hABCD_ABCD, 1'b1, st);
        check("sh.wben", {31'd0, wb_en}, 32'd0);
        run_mem("sw", F_SW, 32'h104, 32'hDEAD_BEEF, 5'd0, 2, 32'd0,
                32'h104, 4'b1111, 32'hDEAD_BEEF, 1'b1, st);
        check("sw.stallcyc", st, 32'd2);

        // Loads
        run_mem("lb", F_LB, 32'h102, 32'd0, 5'd6, 1, 32'h0080_0000,
                32'h100, 4'b0000, 32'd0, 1'b0, st);
        check("lb.stallcyc", st, 32'd1);
        check("lb.wbd",  wb_data, 32'hFFFF_FF80);
        check("lb.wben", {31'd0, wb_en}, 32'd1);
        check("lb.rd",   {27'd0, rd_out}, 32'd6);
        check("lb.func", {26'd0, func_out}, {26'd0, F_LB});
        run_mem("lbu", F_LBU, 32'h102, 32'd0, 5'd6, 2, 32'h0080_0000,
                32'h100, 4'b0000, 32'd0, 1'b0, st);
        check("lbu.wbd", wb_data, 32'h0000_0080);
        run_mem("lh", F_LH, 32'h102, 32'd0, 5'd8, 1, 32'h8001_0000,
                32'h100, 4'b0000, 32'd0, 1'b0, st);
        check("lh.wbd", wb_data, 32'hFFFF_8001);
        run_mem("lhu", F_LHU, 32'h100, 32'd0, 5'd8, 1, 32'h8001_7FFF,
                32'h100, 4'b0000, 32'd0, 1'b0, st);
        check("lhu.wbd", wb_data, 32'h0000_7FFF);
        run_mem("lb_r0", F_LB, 32'h203, 32'd0, 5'd0, 1, 32'hF700_0000,
                32'h200, 4'b0000, 32'd0, 1'b0, st);
        check("lb_r0.wbd",  wb_data, 32'hFFFF_FFF7);
        check("lb_r0.wben", {31'd0, wb_en}, 32'd0);

        // Misaligned accesses
        drive(F_LW, 32'h102, 32'd0, 5'd4);
        @(negedge clk);
        check("lw_mis.pulse", {31'd0, misalign}, 32'd1);
        check("lw_mis.req",   {31'd0, mem_req}, 32'd0);
        check("lw_mis.wben",  {31'd0, wb_en}, 32'd0);
        check("lw_mis.func",  {26'd0, func_out}, {26'd0, F_NOP});
        check("lw_mis.stall", {31'd0, stall_out}, 32'd0);
        drive(F_LH, 32'h101, 32'd0, 5'd4);
        @(negedge clk);
        check("lh_mis.pulse", {31'd0, misalign}, 32'd1);
        check("lh_mis.req",   {31'd0, mem_req}, 32'd0);
        drive(F_NOP, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        check("mis.clear", {31'd0, misalign}, 32'd0);

        // Timeout: no ack
        drive(F_LW, 32'h200, 32'd0, 5'd9);
        reqs = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(F_NOP, 32'd0, 32'd0, 5'd0);
            if (mem_req) reqs++;
            else break;
        end
        check("to.reqcyc", reqs, 32'd4);
        check("to.berr",   {31'd0, bus_err}, 32'd1);
        check("to.wben",   {31'd0, wb_en}, 32'd0);
        check("to.func",   {26'd0, func_out}, {26'd0, F_NOP});
        check("to.stall",  {31'd0, stall_out}, 32'd0);
        @(negedge clk);
        check("to.berr_clear", {31'd0, bus_err}, 32'd0);

        // Ack in the cycle the count would reach TIMEOUT wins
        run_mem("to_ack", F_LW, 32'h200, 32'd0, 5'd9, 4, 32'hCAFE_F00D,
                32'h200, 4'b0000, 32'd0, 1'b0, st);
        check("to_ack.wbd",  wb_data, 32'hCAFE_F00D);
        check("to_ack.wben", {31'd0, wb_en}, 32'd1);
        check("to_ack.func", {26'd0, func_out}, {26'd0, F_LW});

        // Reset in the middle of BUSY
        drive(F_LW, 32'h300, 32'd0, 5'd10);
        @(negedge clk);
        check("mrst.busy", {31'd0, mem_req}, 32'd1);
        drive(F_NOP, 32'd0, 32'd0, 5'd0);
        #2 rst = 1'b0;
        #1;
        check("mrst.req",   {31'd0, mem_req}, 32'd0);
        check("mrst.stall", {31'd0, stall_out}, 32'd0);
        check("mrst.addr",  mem_addr, 32'd0);
        check("mrst.wben",  {31'd0, wb_en}, 32'd0);
        check("mrst.func",  {26'd0, func_out}, {26'd0, F_NOP});
        @(negedge clk);
        rst = 1'b1;
        run_mem("post", F_LW, 32'h300, 32'd0, 5'd10, 2, 32'h1122_3344,
                32'h300, 4'b0000, 32'd0, 1'b0, st);
        check("post.wbd",  wb_data, 32'h1122_3344);
        check("post.wben", {31'd0, wb_en}, 32'd1);
        check("post.rd",   {27'd0, rd_out}, 32'd10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
